// File: rtl/hub75_shift_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hub75_shift_pkg                                                       |
// | Strobe-mode encodings shared by the HUB75 row shifter.                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package hub75_shift_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_DATA   = 2'd0,
      MODE_ROWSEL = 2'd1,
      MODE_LATCH  = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

endpackage
`default_nettype wire

// File: rtl/hub75_le_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hub75_le_gen                                                          |
// | Segment-position counter and LE strobe compare for one shifted column.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module hub75_le_gen
   import hub75_shift_pkg::*;
#(
   parameter int N_COLS     = 192,
   parameter int SEG_W      = 24,
   parameter int LOG_N_COLS = $clog2(N_COLS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vld_i,
   input  logic [LOG_N_COLS-1:0] k_i,
   input  mode_e                 mode_i,
   input  logic [LOG_N_COLS:0]   arg_i,
   output logic                  le_o
);

   localparam int SPW = (SEG_W > 1) ? $clog2(SEG_W) : 1;
   localparam int AW  = LOG_N_COLS + 1;
   localparam int SW  = LOG_N_COLS + 2;

   logic [SPW-1:0] sp_q, sp_d, sp_cur;
   logic           le_q, le_d;

   always_comb begin
      // k=0 forces the reload so every row starts at the top of a segment
      sp_cur = (k_i == '0) ? SPW'(SEG_W - 1) : sp_q;
      sp_d   = sp_q;
      le_d   = 1'b0;
      if (vld_i) begin
         sp_d = (sp_cur == '0) ? SPW'(SEG_W - 1) : sp_cur - 1'b1;
         case (mode_i)
            MODE_ROWSEL: le_d = (AW'(sp_cur) == arg_i);
            MODE_LATCH:  le_d = ((SW'(k_i) + SW'(arg_i)) >= SW'(N_COLS));
            default:     le_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp_q <= SPW'(SEG_W - 1);
         le_q <= 1'b0;
      end else begin
         sp_q <= sp_d;
         le_q <= le_d;
      end
   end

   assign le_o = le_q;

endmodule
`default_nettype wire

// File: rtl/hub75_shift_seg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hub75_shift_seg                                                       |
// | HUB75 row shifter: line-buffer read, bit-plane select, PHY shift + LE.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module hub75_shift_seg
   import hub75_shift_pkg::*;
#(
   parameter int N_BANKS    = 2,
   parameter int N_COLS     = 192,
   parameter int N_CHANS    = 3,
   parameter int N_PLANES   = 8,
   parameter int SEG_W      = 24,
   parameter int SDW        = N_BANKS * N_CHANS,
   parameter int LOG_N_COLS = $clog2(N_COLS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic [SDW-1:0]          phy_data_o,
   output logic                    phy_clk_o,
   output logic                    phy_le_o,
   input  logic [SDW*N_PLANES-1:0] ram_data_i,
   output logic [LOG_N_COLS-1:0]   ram_col_addr_o,
   output logic                    ram_rden_o,
   input  logic                    ctrl_go_i,
   output logic                    ctrl_rdy_o,
   input  logic [N_PLANES-1:0]     ctrl_plane_i,
   input  logic [MODE_W-1:0]       ctrl_mode_i,
   input  logic [LOG_N_COLS:0]     ctrl_arg_i,
   input  logic                    ctrl_reverse_i
);

   localparam logic [LOG_N_COLS-1:0] LAST_COL = LOG_N_COLS'(N_COLS - 1);

   if (((N_COLS % SEG_W) != 0) || (SEG_W > N_COLS)) begin : g_bad_geometry
      $fatal(1, "hub75_shift_seg: N_COLS must be a multiple of SEG_W and SEG_W <= N_COLS");
   end

   // Stage 0: address generation and captured row configuration
   logic                  s0_vld_q, s0_vld_d;
   logic [LOG_N_COLS-1:0] k_q, k_d;
   logic [N_PLANES-1:0]   plane0_q, plane0_d;
   mode_e                 mode0_q, mode0_d;
   logic [LOG_N_COLS:0]   arg0_q, arg0_d;
   logic                  rev0_q, rev0_d;

   // Stage 1: RAM word arrives; configuration follows its column
   logic                  s1_vld_q;
   logic [LOG_N_COLS-1:0] k1_q;
   logic [N_PLANES-1:0]   plane1_q;
   mode_e                 mode1_q;
   logic [LOG_N_COLS:0]   arg1_q;

   // Stage 2: PHY outputs
   logic                  phy_clk_q;
   logic [SDW-1:0]        phy_data_q, phy_data_d;
   logic [SDW-1:0]        chan_bit;

   logic last_col, rdy, go_acc;

   always_comb begin
      last_col = s0_vld_q && (k_q == LAST_COL);
      rdy      = !s0_vld_q || last_col;
      go_acc   = ctrl_go_i && rdy;
      s0_vld_d = s0_vld_q && !last_col;
      k_d      = k_q;
      plane0_d = plane0_q;
      mode0_d  = mode0_q;
      arg0_d   = arg0_q;
      rev0_d   = rev0_q;
      if (s0_vld_q && !last_col) begin
         k_d = k_q + 1'b1;
      end
      if (go_acc) begin
         s0_vld_d = 1'b1;
         k_d      = '0;
         plane0_d = ctrl_plane_i;
         mode0_d  = mode_e'(ctrl_mode_i);
         arg0_d   = ctrl_arg_i;
         rev0_d   = ctrl_reverse_i;
      end
   end

   for (genvar ch = 0; ch < SDW; ch++) begin : g_chan
      assign chan_bit[ch] = |(ram_data_i[ch*N_PLANES +: N_PLANES] & plane1_q);
   end

   assign phy_data_d = s1_vld_q ? chan_bit : phy_data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s0_vld_q   <= 1'b0;
         k_q        <= '0;
         plane0_q   <= '0;
         mode0_q    <= MODE_DATA;
         arg0_q     <= '0;
         rev0_q     <= 1'b0;
         s1_vld_q   <= 1'b0;
         k1_q       <= '0;
         plane1_q   <= '0;
         mode1_q    <= MODE_DATA;
         arg1_q     <= '0;
         phy_clk_q  <= 1'b0;
         phy_data_q <= '0;
      end else begin
         s0_vld_q   <= s0_vld_d;
         k_q        <= k_d;
         plane0_q   <= plane0_d;
         mode0_q    <= mode0_d;
         arg0_q     <= arg0_d;
         rev0_q     <= rev0_d;
         s1_vld_q   <= s0_vld_q;
         k1_q       <= k_q;
         plane1_q   <= plane0_q;
         mode1_q    <= mode0_q;
         arg1_q     <= arg0_q;
         phy_clk_q  <= s1_vld_q;
         phy_data_q <= phy_data_d;
      end
   end

   hub75_le_gen #(
      .N_COLS     (N_COLS),
      .SEG_W      (SEG_W),
      .LOG_N_COLS (LOG_N_COLS)
   ) u_le_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (s1_vld_q),
      .k_i    (k1_q),
      .mode_i (mode1_q),
      .arg_i  (arg1_q),
      .le_o   (phy_le_o)
   );

   assign ctrl_rdy_o     = rdy;
   assign ram_rden_o     = s0_vld_q;
   assign ram_col_addr_o = !s0_vld_q ? '0 : (rev0_q ? (LAST_COL - k_q) : k_q);
   assign phy_clk_o      = phy_clk_q;
   assign phy_data_o     = phy_data_q;

endmodule
`default_nettype wire
